edf_ic_nest: RTL and testbench
==============================

# edf_ic_nest

Parametrised successor EDF interrupt controller: per-line relative deadlines, absolute deadlines stamped from `mtime_i` when a line pends, and wrap-safe earliest-deadline arbitration. Adds a claim/complete handshake with a nesting stack, so only an interrupt with an earlier deadline than the one in service can preempt. Also adds deadline-miss detection. Sits between external interrupt sources/memory-mapped config bus and the core's interrupt port.

## Interface
- `NrIrqs`, 8, number of interrupt lines (≥2)
- `TsWidth`, 24, deadline width in ticks
- `TsClip`, 4, low `mtime_i` bits dropped (tick = 2^TsClip cycles of mtime)
- `NestDepth`, 4, max in-service (nested) interrupts
- `IdWidth` (local), $clog2(NrIrqs); `OutTsWidth` (local), TsWidth+TsClip
- `clk_i` in 1 — single clock
- `rst_ni` in 1 — asynchronous, active-low reset
- `cfg_req_i`, `cfg_we_i` in 1 each — config request / write enable
- `cfg_addr_i` in 32 — byte address; line = addr[IdWidth+2:3], word = addr[2]
- `cfg_wdata_i` in 32; `cfg_rdata_o` out 32 — combinational read data
- `mtime_i` in 64 — platform time
- `irq_i` in NrIrqs — raw sources
- `irq_valid_o` out 1 — preempting interrupt available
- `irq_id_o` out IdWidth; `irq_dl_o` out OutTsWidth — winner id, absolute deadline {adl, TsClip'0}
- `irq_claim_i` in 1 — core takes winner
- `irq_complete_i` in 1 — core finishes innermost handler
- `miss_o` out 1 — OR of all line miss flags
- `nest_lvl_o` out $clog2(NestDepth+1) — stack occupancy

## Operation
- Per line state: ie, ip, trig_type, trig_pol, miss, rdl[TsWidth], adl[TsWidth].
- Word 0 (ctrl): bit0 ie, bit1 ip, bit2 trig_type, bit3 trig_pol, bit4 miss (write-1-to-clear), rest 0. Word 1: rdl in [TsWidth-1:0]. Read returns these; adl read at word 1 bits [31:TsWidth]? No — word 1 read returns rdl only; adl visible only via `irq_dl_o`.
- cfg_rdata_o = 0 when no read request.
- Pend: gateway event or SW write ip 0→1 sets ip and adl = now + rdl, now = mtime_i[TsWidth+TsClip-1:TsClip], mod 2^TsWidth. rdl never modified by hardware.
- Ordering: a before b iff MSB of (a − b) is 1. Valid while live deadlines span < 2^(TsWidth-1) ticks.
- Candidates: ie & ip. Winner = earliest adl; ties → lowest id. Registered each cycle.
- Miss: enabled pending line with MSB of (adl − now) = 1, or adl == now, sets miss. Miss persists until SW W1C; ip unaffected.
- Stack entries {id, adl}. irq_valid_o = winner valid & stack not full & (stack empty | winner before top.adl) & ~blank.
- Claim with irq_valid_o=1: clear winner ip, push {id, adl}, set blank for one cycle. Claim with irq_valid_o=0: ignored.
- Complete: pop; ignored when empty.
- Claim + complete same cycle: pop then push (top replaced).
- Write + gateway event same line same cycle: event owns ip/adl; write sets other fields. Claim clear beats a same-cycle event on that line.

## Timing
- Reset: all line state 0, stack empty, blank 0; outputs irq_valid_o=0, irq_id_o=0, irq_dl_o=0, miss_o=0, nest_lvl_o=0, cfg_rdata_o=0.
- Edge on `irq_i` in cycle n: gateway pulse in cycle n; ip/adl set at n+1; irq_valid_o high at n+2.
- Claim in cycle c: irq_valid_o forced 0 in c+1 (blank); arbitration reflects cleared ip from c+2.
- Complete in cycle c: nest_lvl_o decrements at c+1; new valid decision at c+1.
- Miss flag set the cycle after the condition; miss_o same cycle as flag.
- Level-triggered line still asserted after claim re-pends next cycle with fresh adl.

## Structure
- Package `edf_pkg`: line_t struct, ctrl bit positions, word offsets, `dl_before` function.
- Sub-modules: reuse `irq_gateway` for edge/level detection; new `edf_nest_stack` (NestDepth-deep LIFO, push/pop/top/full/empty/level).
- Arbiter tree is inline, with a registered output.

## Test plan
- Line 2 rdl=100, ie=1, edge, mtime tick=50 → irq_valid_o at n+2, id=2, irq_dl_o={150,TsClip'0}.
- Lines 1 (adl 300) and 3 (adl 200) pending → id 3; claim → nest_lvl_o=1, valid 0 one cycle, then 0 since 300 not before 200.
- Nesting: in service adl=500; line 0 pends adl=400 → valid, claim, level 2; complete twice → level 0; extra complete ignored.
- Wrap: now=2^24−10, rdl=20 → adl=10; line with adl=2^24−5 wins over it.
- Miss: rdl=5, never claimed → miss bit and miss_o set at tick 5+1 cycle; W1C clears; ip still 1.
- Stack full (4 nested) → irq_valid_o=0 despite earlier deadline; reset mid-nest → all outputs 0.

Source files
------------

// File: rtl/edf_pkg.sv
// Shared types, control-word layout and wrap-safe deadline ordering for the
// nesting EDF interrupt controller.
package edf_pkg;

    localparam int unsigned CtrlIe       = 0;
    localparam int unsigned CtrlIp       = 1;
    localparam int unsigned CtrlTrigType = 2;
    localparam int unsigned CtrlTrigPol  = 3;
    localparam int unsigned CtrlMiss     = 4;

    localparam logic WordCtrl = 1'b0;
    localparam logic WordRdl  = 1'b1;

    // Member order makes the packed value identical to ctrl word bits [4:0].
    typedef struct packed {
        logic miss;
        logic trig_pol;
        logic trig_type;
        logic ip;
        logic ie;
    } line_t;

    // a is earlier than b when (a - b) is negative in a width-bit ring.
    function automatic logic dl_before(input logic [31:0] a, input logic [31:0] b,
                                       input int unsigned width);
        logic [31:0] diff;
        logic [4:0]  msb;
        diff = a - b;
        msb  = 5'(width - 1);
        return diff[msb];
    endfunction

endpackage

// File: rtl/edf_nest_stack.sv
// LIFO of in-service {id, deadline} entries; a simultaneous pop and push
// replaces the top entry in place.
module edf_nest_stack #(
    parameter  int unsigned Depth     = 4,
    parameter  int unsigned DataWidth = 27,
    localparam int unsigned LvlWidth  = $clog2(Depth + 1),
    localparam int unsigned PtrWidth  = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DataWidth-1:0] push_data,
    output logic [DataWidth-1:0] top,
    output logic                 full,
    output logic                 empty,
    output logic [LvlWidth-1:0]  level
);

    logic [DataWidth-1:0] mem [Depth];
    logic [LvlWidth-1:0]  count;
    logic [PtrWidth-1:0]  top_ptr, free_ptr;

    assign top_ptr  = PtrWidth'(count - LvlWidth'(1));
    assign free_ptr = PtrWidth'(count);
    assign empty    = (count == '0);
    assign full     = (count == LvlWidth'(Depth));
    assign level    = count;
    assign top      = empty ? '0 : mem[top_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
            for (int i = 0; i < Depth; i++) mem[i] <= '0;
        end else if (pop && !empty) begin
            if (push) mem[top_ptr] <= push_data;
            else      count <= count - LvlWidth'(1);
        end else if (push && !full) begin
            mem[free_ptr] <= push_data;
            count         <= count + LvlWidth'(1);
        end
    end

endmodule

// File: rtl/irq_gateway.sv
// Per-line source conditioning: level mode passes the active level through,
// edge mode emits a one-cycle pulse on the active transition.
module irq_gateway #(
    parameter int unsigned NrIrqs = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NrIrqs-1:0] irq_i,
    input  logic [NrIrqs-1:0] trig_type,
    input  logic [NrIrqs-1:0] trig_pol,
    output logic [NrIrqs-1:0] pulse
);

    logic [NrIrqs-1:0] irq_prev;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) irq_prev <= '0;
        else         irq_prev <= irq_i;
    end

    for (genvar gi = 0; gi < NrIrqs; gi++) begin : g_line
        logic rise, fall;
        assign rise      = irq_i[gi] & ~irq_prev[gi];
        assign fall      = ~irq_i[gi] & irq_prev[gi];
        assign pulse[gi] = trig_type[gi] ? (trig_pol[gi] ? fall : rise)
                                         : (irq_i[gi] ^ trig_pol[gi]);
    end

endmodule

// File: rtl/edf_ic_nest.sv
// EDF interrupt controller with claim/complete nesting: only a strictly
// earlier deadline than the innermost in-service one is offered to the core.
module edf_ic_nest import edf_pkg::*; #(
    parameter  int unsigned NrIrqs     = 8,
    parameter  int unsigned TsWidth    = 24,
    parameter  int unsigned TsClip     = 4,
    parameter  int unsigned NestDepth  = 4,
    localparam int unsigned IdWidth    = $clog2(NrIrqs),
    localparam int unsigned OutTsWidth = TsWidth + TsClip,
    localparam int unsigned LvlWidth   = $clog2(NestDepth + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cfg_req_i,
    input  logic                  cfg_we_i,
    input  logic [31:0]           cfg_addr_i,
    input  logic [31:0]           cfg_wdata_i,
    output logic [31:0]           cfg_rdata_o,
    input  logic [63:0]           mtime_i,
    input  logic [NrIrqs-1:0]     irq_i,
    output logic                  irq_valid_o,
    output logic [IdWidth-1:0]    irq_id_o,
    output logic [OutTsWidth-1:0] irq_dl_o,
    input  logic                  irq_claim_i,
    input  logic                  irq_complete_i,
    output logic                  miss_o,
    output logic [LvlWidth-1:0]   nest_lvl_o
);

    logic [TsWidth-1:0]       now;
    logic [IdWidth-1:0]       cfg_line;
    logic                     cfg_word, cfg_line_ok;
    line_t                    line_state [NrIrqs];
    logic [TsWidth-1:0]       rdl_state  [NrIrqs];
    logic [TsWidth-1:0]       adl_state  [NrIrqs];
    logic [NrIrqs-1:0]        trig_type, trig_pol, gw_pulse, cand, miss_vec;
    logic                     best_valid, win_valid, blank, claim_fire, offer;
    logic [IdWidth-1:0]       best_id, win_id;
    logic [TsWidth-1:0]       best_dl, win_dl, top_adl;
    logic [IdWidth+TsWidth-1:0] top_data;
    logic                     stk_full, stk_empty;
    logic                     unused_bits;

    assign now         = mtime_i[TsWidth+TsClip-1:TsClip];
    assign cfg_line    = cfg_addr_i[IdWidth+2:3];
    assign cfg_word    = cfg_addr_i[2];
    assign cfg_line_ok = (32'(cfg_line) < NrIrqs);
    assign unused_bits = ^{mtime_i, cfg_addr_i, cfg_wdata_i, top_data};

    irq_gateway #(.NrIrqs(NrIrqs)) u_gateway (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .irq_i     (irq_i),
        .trig_type (trig_type),
        .trig_pol  (trig_pol),
        .pulse     (gw_pulse)
    );

    for (genvar gi = 0; gi < NrIrqs; gi++) begin : g_line
        line_t              line;
        logic [TsWidth-1:0] rdl, adl;
        logic               late, overdue, wr_ctrl, wr_rdl, claim_clr, stamp;

        assign wr_ctrl   = cfg_req_i & cfg_we_i & cfg_line_ok
                           & (cfg_line == IdWidth'(gi)) & (cfg_word == WordCtrl);
        assign wr_rdl    = cfg_req_i & cfg_we_i & cfg_line_ok
                           & (cfg_line == IdWidth'(gi)) & (cfg_word == WordRdl);
        assign claim_clr = claim_fire & (win_id == IdWidth'(gi));
        // Deadline is stamped only on a 0->1 pend so a held level cannot slide it.
        assign stamp     = ~claim_clr & ~line.ip
                           & (gw_pulse[gi] | (wr_ctrl & cfg_wdata_i[CtrlIp]));
        assign overdue   = line.ie & line.ip
                           & (dl_before(32'(adl), 32'(now), TsWidth) | (adl == now));

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                line <= '0;
                rdl  <= '0;
                adl  <= '0;
                late <= 1'b0;
            end else begin
                late <= overdue;
                if (wr_ctrl) begin
                    line.ie        <= cfg_wdata_i[CtrlIe];
                    line.trig_type <= cfg_wdata_i[CtrlTrigType];
                    line.trig_pol  <= cfg_wdata_i[CtrlTrigPol];
                end
                if (claim_clr)         line.ip <= 1'b0;
                else if (gw_pulse[gi]) line.ip <= 1'b1;
                else if (wr_ctrl)      line.ip <= cfg_wdata_i[CtrlIp];
                // Miss is raised once on entering the overdue state, so a clear sticks.
                if (overdue && !late)                      line.miss <= 1'b1;
                else if (wr_ctrl && cfg_wdata_i[CtrlMiss]) line.miss <= 1'b0;
                if (wr_rdl) rdl <= cfg_wdata_i[TsWidth-1:0];
                if (stamp)  adl <= now + rdl;
            end
        end

        assign line_state[gi] = line;
        assign rdl_state[gi]  = rdl;
        assign adl_state[gi]  = adl;
        assign trig_type[gi]  = line.trig_type;
        assign trig_pol[gi]   = line.trig_pol;
        assign cand[gi]       = line.ie & line.ip;
        assign miss_vec[gi]   = line.miss;
    end

    always_comb begin
        cfg_rdata_o = '0;
        if (cfg_req_i && !cfg_we_i && cfg_line_ok) begin
            if (cfg_word == WordCtrl)
                cfg_rdata_o = {{(32-$bits(line_t)){1'b0}}, line_state[cfg_line]};
            else
                cfg_rdata_o = 32'(rdl_state[cfg_line]);
        end
    end

    // Priority scan: strict "before" keeps the lowest id on equal deadlines.
    always_comb begin
        best_valid = 1'b0;
        best_id    = '0;
        best_dl    = '0;
        for (int i = 0; i < NrIrqs; i++) begin
            if (cand[i] && (!best_valid
                            || dl_before(32'(adl_state[i]), 32'(best_dl), TsWidth))) begin
                best_valid = 1'b1;
                best_id    = IdWidth'(i);
                best_dl    = adl_state[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            win_valid <= 1'b0;
            win_id    <= '0;
            win_dl    <= '0;
            blank     <= 1'b0;
        end else begin
            win_valid <= best_valid;
            win_id    <= best_id;
            win_dl    <= best_dl;
            blank     <= claim_fire;
        end
    end

    edf_nest_stack #(.Depth(NestDepth), .DataWidth(IdWidth + TsWidth)) u_stack (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push      (claim_fire),
        .pop       (irq_complete_i),
        .push_data ({win_id, win_dl}),
        .top       (top_data),
        .full      (stk_full),
        .empty     (stk_empty),
        .level     (nest_lvl_o)
    );

    assign top_adl     = top_data[TsWidth-1:0];
    assign offer       = win_valid & ~stk_full & ~blank
                         & (stk_empty | dl_before(32'(win_dl), 32'(top_adl), TsWidth));
    assign claim_fire  = irq_claim_i & offer;
    assign irq_valid_o = offer;
    assign irq_id_o    = win_id;
    assign irq_dl_o    = OutTsWidth'(win_dl) << TsClip;
    assign miss_o      = |miss_vec;

endmodule

// File: tb/tb_edf_ic_nest.sv
// Directed bench for edf_ic_nest: each task drives one scenario and checks
// outputs one time unit after the rising edge against hand-computed values.
module tb_edf_ic_nest;

    localparam int TsClip = 4;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cfg_req_i = 1'b0, cfg_we_i = 1'b0;
    logic [31:0] cfg_addr_i = '0, cfg_wdata_i = '0, cfg_rdata_o;
    logic [63:0] mtime_i = '0;
    logic [7:0]  irq_i = '0;
    logic        irq_valid_o, irq_claim_i = 1'b0, irq_complete_i = 1'b0, miss_o;
    logic [2:0]  irq_id_o, nest_lvl_o;
    logic [27:0] irq_dl_o;
    logic [31:0] rd;
    int          checks = 0, errors = 0;

    edf_ic_nest dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .cfg_req_i      (cfg_req_i),
        .cfg_we_i       (cfg_we_i),
        .cfg_addr_i     (cfg_addr_i),
        .cfg_wdata_i    (cfg_wdata_i),
        .cfg_rdata_o    (cfg_rdata_o),
        .mtime_i        (mtime_i),
        .irq_i          (irq_i),
        .irq_valid_o    (irq_valid_o),
        .irq_id_o       (irq_id_o),
        .irq_dl_o       (irq_dl_o),
        .irq_claim_i    (irq_claim_i),
        .irq_complete_i (irq_complete_i),
        .miss_o         (miss_o),
        .nest_lvl_o     (nest_lvl_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tick(input longint t);
        mtime_i = 64'(t) << TsClip;
    endtask

    task automatic cfg_write(input int line, input int word, input logic [31:0] data);
        cfg_req_i   = 1'b1;
        cfg_we_i    = 1'b1;
        cfg_addr_i  = 32'((line << 3) | (word << 2));
        cfg_wdata_i = data;
        tick();
        cfg_req_i   = 1'b0;
        cfg_we_i    = 1'b0;
    endtask

    task automatic cfg_read(input int line, input int word, output logic [31:0] data);
        cfg_req_i  = 1'b1;
        cfg_we_i   = 1'b0;
        cfg_addr_i = 32'((line << 3) | (word << 2));
        #1;
        data       = cfg_rdata_o;
        cfg_req_i  = 1'b0;
    endtask

    task automatic claim();
        irq_claim_i = 1'b1;
        tick();
        irq_claim_i = 1'b0;
    endtask

    task automatic complete();
        irq_complete_i = 1'b1;
        tick();
        irq_complete_i = 1'b0;
    endtask

    task automatic apply_reset();
        rst_ni  = 1'b0;
        irq_i   = '0;
        mtime_i = '0;
        tick();
        tick();
        rst_ni  = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        tick();
        checks++; if (irq_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", irq_valid_o); end
        checks++; if (irq_id_o !== 3'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", irq_id_o); end
        checks++; if (irq_dl_o !== 28'd0) begin errors++; $display("FAIL reset_dl: got %0d expected 0", irq_dl_o); end
        checks++; if (miss_o !== 1'b0) begin errors++; $display("FAIL reset_miss: got %0b expected 0", miss_o); end
        checks++; if (nest_lvl_o !== 3'd0) begin errors++; $display("FAIL reset_lvl: got %0d expected 0", nest_lvl_o); end
        checks++; if (cfg_rdata_o !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %0h expected 0", cfg_rdata_o); end
        rst_ni = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_edge();
        apply_reset();
        set_tick(50);
        cfg_write(2, 1, 32'd100);
        cfg_write(2, 0, 32'h5);
        irq_i[2] = 1'b1;
        tick();
        checks++; if (irq_valid_o !== 1'b0) begin errors++; $display("FAIL edge_valid_n1: got %0b expected 0", irq_valid_o); end
        tick();
        checks++; if (irq_valid_o !== 1'b1) begin errors++; $display("FAIL edge_valid_n2: got %0b expected 1", irq_valid_o); end
        checks++; if (irq_id_o !== 3'd2) begin errors++; $display("FAIL edge_id: got %0d expected 2", irq_id_o); end
        checks++; if (irq_dl_o !== 28'd2400) begin errors++; $display("FAIL edge_dl: got %0d expected 2400", irq_dl_o); end
        cfg_read(2, 0, rd);
        checks++; if (rd !== 32'h7) begin errors++; $display("FAIL edge_ctrl_read: got %0h expected 7", rd); end
        cfg_read(2, 1, rd);
        checks++; if (rd !== 32'd100) begin errors++; $display("FAIL edge_rdl_read: got %0d expected 100", rd); end
        irq_i[2] = 1'b0;
        $display("test_edge done");
    endtask

    task automatic test_order();
        apply_reset();
        set_tick(0);
        cfg_write(1, 1, 32'd300);
        cfg_write(3, 1, 32'd200);
        cfg_write(1, 0, 32'h3);
        cfg_write(3, 0, 32'h3);
        tick();
        checks++; if (irq_valid_o !== 1'b1) begin errors++; $display("FAIL order_valid: got %0b expected 1", irq_valid_o); end
        checks++; if (irq_id_o !== 3'd3) begin errors++; $display("FAIL order_id: got %0d expected 3", irq_id_o); end
        checks++; if (irq_dl_o !== 28'd3200) begin errors++; $display("FAIL order_dl: got %0d expected 3200", irq_dl_o); end
        claim();
        checks++; if (nest_lvl_o !== 3'd1) begin errors++; $display("FAIL order_lvl: got %0d expected 1", nest_lvl_o); end
        checks++; if (irq_valid_o !== 1'b0) begin errors++; $display("FAIL order_blank: got %0b expected 0", irq_valid_o); end
        tick();
        checks++; if (irq_valid_o !== 1'b0) begin errors++; $display("FAIL order_no_preempt: got %0b expected 0", irq_valid_o); end
        checks++; if (irq_id_o !== 3'd1) begin errors++; $display("FAIL order_next_id: got %0d expected 1", irq_id_o); end
        cfg_read(3, 0, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL order_ip_cleared: got %0h expected 1", rd); end
        $display("test_order done");
    endtask

    task automatic test_nest();
        apply_reset();
        set_tick(0);
        cfg_write(5, 1, 32'd500);
        cfg_write(5, 0, 32'h3);
        tick();
        claim();
        checks++; if (nest_lvl_o !== 3'd1) begin errors++; $display("FAIL nest_lvl1: got %0d expected 1", nest_lvl_o); end
        cfg_write(0, 1, 32'd400);
        cfg_write(0, 0, 32'h3);
        tick();
        checks++; if (irq_valid_o !== 1'b1) begin errors++; $display("FAIL nest_preempt_valid: got %0b expected 1", irq_valid_o); end
        checks++; if (irq_id_o !== 3'd0) begin errors++; $display("FAIL nest_preempt_id: got %0d expected 0", irq_id_o); end
        claim();
        checks++; if (nest_lvl_o !== 3'd2) begin errors++; $display("FAIL nest_lvl2: got %0d expected 2", nest_lvl_o); end
        complete();
        checks++; if (nest_lvl_o !== 3'd1) begin errors++; $display("FAIL nest_pop1: got %0d expected 1", nest_lvl_o); end
        complete();
        checks++; if (nest_lvl_o !== 3'd0) begin errors++; $display("FAIL nest_pop2: got %0d expected 0", nest_lvl_o); end
        complete();
        checks++; if (nest_lvl_o !== 3'd0) begin errors++; $display("FAIL nest_pop_empty: got %0d expected 0", nest_lvl_o); end
        $display("test_nest done");
    endtask

    task automatic test_wrap();
        apply_reset();
        set_tick(64'd16777216 - 64'd10);
        cfg_write(4, 1, 32'd20);
        cfg_write(6, 1, 32'd5);
        cfg_write(4, 0, 32'h3);
        cfg_write(6, 0, 32'h3);
        tick();
        checks++; if (irq_id_o !== 3'd6) begin errors++; $display("FAIL wrap_id: got %0d expected 6", irq_id_o); end
        checks++; if (irq_dl_o !== 28'hFFFFFB0) begin errors++; $display("FAIL wrap_dl: got %0h expected FFFFFB0", irq_dl_o); end
        checks++; if (miss_o !== 1'b0) begin errors++; $display("FAIL wrap_no_miss: got %0b expected 0", miss_o); end
        cfg_write(6, 0, 32'h1);
        tick();
        checks++; if (irq_id_o !== 3'd4) begin errors++; $display("FAIL wrap_next_id: got %0d expected 4", irq_id_o); end
        checks++; if (irq_dl_o !== 28'h00000A0) begin errors++; $display("FAIL wrap_next_dl: got %0h expected A0", irq_dl_o); end
        $display("test_wrap done");
    endtask

    task automatic test_miss();
        apply_reset();
        set_tick(1000);
        cfg_write(7, 1, 32'd5);
        cfg_write(7, 0, 32'h3);
        set_tick(1004);
        tick();
        tick();
        checks++; if (miss_o !== 1'b0) begin errors++; $display("FAIL miss_early: got %0b expected 0", miss_o); end
        set_tick(1005);
        #1;
        checks++; if (miss_o !== 1'b0) begin errors++; $display("FAIL miss_same_cycle: got %0b expected 0", miss_o); end
        tick();
        checks++; if (miss_o !== 1'b1) begin errors++; $display("FAIL miss_set: got %0b expected 1", miss_o); end
        cfg_read(7, 0, rd);
        checks++; if (rd !== 32'h13) begin errors++; $display("FAIL miss_ctrl_read: got %0h expected 13", rd); end
        cfg_write(7, 0, 32'h13);
        checks++; if (miss_o !== 1'b0) begin errors++; $display("FAIL miss_w1c: got %0b expected 0", miss_o); end
        cfg_read(7, 0, rd);
        checks++; if (rd !== 32'h3) begin errors++; $display("FAIL miss_ip_kept: got %0h expected 3", rd); end
        tick();
        checks++; if (miss_o !== 1'b0) begin errors++; $display("FAIL miss_stays_clear: got %0b expected 0", miss_o); end
        $display("test_miss done");
    endtask

    task automatic test_full();
        apply_reset();
        set_tick(0);
        for (int k = 0; k < 4; k++) begin
            cfg_write(k, 1, 32'(400 - 100 * k));
            cfg_write(k, 0, 32'h3);
            tick();
            checks++; if (irq_valid_o !== 1'b1) begin errors++; $display("FAIL full_fill_valid[%0d]: got %0b expected 1", k, irq_valid_o); end
            claim();
        end
        checks++; if (nest_lvl_o !== 3'd4) begin errors++; $display("FAIL full_lvl: got %0d expected 4", nest_lvl_o); end
        cfg_write(4, 1, 32'd50);
        cfg_write(4, 0, 32'h3);
        tick();
        checks++; if (irq_valid_o !== 1'b0) begin errors++; $display("FAIL full_blocked: got %0b expected 0", irq_valid_o); end
        checks++; if (irq_id_o !== 3'd4) begin errors++; $display("FAIL full_winner: got %0d expected 4", irq_id_o); end
        complete();
        checks++; if (nest_lvl_o !== 3'd3) begin errors++; $display("FAIL full_pop_lvl: got %0d expected 3", nest_lvl_o); end
        checks++; if (irq_valid_o !== 1'b1) begin errors++; $display("FAIL full_pop_valid: got %0b expected 1", irq_valid_o); end
        rst_ni = 1'b0;
        #1;
        checks++; if (irq_valid_o !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %0b expected 0", irq_valid_o); end
        checks++; if (irq_id_o !== 3'd0) begin errors++; $display("FAIL midreset_id: got %0d expected 0", irq_id_o); end
        checks++; if (irq_dl_o !== 28'd0) begin errors++; $display("FAIL midreset_dl: got %0d expected 0", irq_dl_o); end
        checks++; if (nest_lvl_o !== 3'd0) begin errors++; $display("FAIL midreset_lvl: got %0d expected 0", nest_lvl_o); end
        tick();
        rst_ni = 1'b1;
        tick();
        $display("test_full done");
    endtask

    task automatic test_back_to_back();
        apply_reset();
        set_tick(0);
        cfg_write(1, 1, 32'd10);
        cfg_write(1, 0, 32'h1);
        irq_i[1] = 1'b1;
        tick();
        tick();
        checks++; if (irq_valid_o !== 1'b1) begin errors++; $display("FAIL level_valid: got %0b expected 1", irq_valid_o); end
        checks++; if (irq_dl_o !== 28'd160) begin errors++; $display("FAIL level_dl: got %0d expected 160", irq_dl_o); end
        claim();
        set_tick(7);
        tick();
        cfg_read(1, 0, rd);
        checks++; if (rd !== 32'h3) begin errors++; $display("FAIL level_repend_ip: got %0h expected 3", rd); end
        checks++; if (irq_valid_o !== 1'b0) begin errors++; $display("FAIL level_gap: got %0b expected 0", irq_valid_o); end
        tick();
        checks++; if (irq_id_o !== 3'd1) begin errors++; $display("FAIL level_repend_id: got %0d expected 1", irq_id_o); end
        checks++; if (irq_dl_o !== 28'd272) begin errors++; $display("FAIL level_fresh_dl: got %0d expected 272", irq_dl_o); end
        checks++; if (irq_valid_o !== 1'b0) begin errors++; $display("FAIL level_no_preempt: got %0b expected 0", irq_valid_o); end
        irq_i[1] = 1'b0;
        $display("test_back_to_back done");
    endtask

    initial begin
        test_reset();
        test_edge();
        test_order();
        test_nest();
        test_wrap();
        test_miss();
        test_full();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
